// File: rtl/sid_pkg.sv
// Shared types for the SID command path: the queued write record and the
// parser/bus state encodings.
package sid_pkg;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  localparam logic [4:0] SID_ADDR_MAX = 5'h1F;

  typedef enum logic {P_ADDR, P_DATA} parser_state_t;
  typedef enum logic {B_IDLE, B_ACTIVE} bus_state_t;

endpackage

// File: rtl/sid_wr_fifo.sv
// Small synchronous FIFO holding decoded SID writes between the byte parser
// and the clk_en-paced bus sequencer. Head entry is readable combinationally
// from the storage array; pops advance the read pointer.
module sid_wr_fifo
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = sid_wr_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == (AW+1)'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sid_cmd_parser.sv
// Turns the UART byte stream into SID register writes: address/data pairs
// are validated, queued, and replayed onto the mos6581 bus one write per
// clk_en period with an n_cs low pulse lasting exactly one clk_en period.
module sid_cmd_parser
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   clk_en,
  output logic [4:0]             sid_addr,
  output logic [7:0]             sid_data,
  output logic                   sid_n_cs,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             err_count,
  output logic                   busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  parser_state_t r_p_state, w_p_next;
  logic [4:0]    r_addr_lat, w_addr_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic          w_accept;
  logic          w_push;
  logic          w_err;

  bus_state_t    r_b_state, w_b_next;
  logic          w_pop;
  logic [4:0]    r_sid_addr;
  logic [7:0]    r_sid_data;
  logic          r_sid_n_cs;
  logic [7:0]    r_err_count;

  sid_wr_t       w_din;
  sid_wr_t       w_dout;
  logic          w_full;
  logic          w_empty;

  sid_wr_fifo #(
    .DEPTH (DEPTH),
    .T     (sid_wr_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign s_axis_tready = ~w_full;
  assign w_accept      = s_axis_tvalid & ~w_full;
  assign w_din         = '{addr: r_addr_lat, data: s_axis_tdata};
  assign sid_addr      = r_sid_addr;
  assign sid_data      = r_sid_data;
  assign sid_n_cs      = r_sid_n_cs;
  assign err_count     = r_err_count;
  assign busy          = ~w_empty | (r_b_state == B_ACTIVE);

  // Parser next-state: an accepted byte always takes priority over timeout.
  always_comb begin
    w_p_next     = r_p_state;
    w_addr_next  = r_addr_lat;
    w_timer_next = r_timer;
    w_push       = 1'b0;
    w_err        = 1'b0;
    case (r_p_state)
      P_ADDR: begin
        if (w_accept) begin
          if (s_axis_tdata <= {3'b000, SID_ADDR_MAX}) begin
            w_addr_next  = s_axis_tdata[4:0];
            w_timer_next = '0;
            w_p_next     = P_DATA;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      P_DATA: begin
        if (w_accept) begin
          w_push   = 1'b1;
          w_p_next = P_ADDR;
        end else if (r_timer == TIMER_LAST) begin
          w_err    = 1'b1;
          w_p_next = P_ADDR;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      default: w_p_next = P_ADDR;
    endcase
  end

  // Parser state, latched address and orphan timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_state  <= P_ADDR;
      r_addr_lat <= '0;
      r_timer    <= '0;
    end else begin
      r_p_state  <= w_p_next;
      r_addr_lat <= w_addr_next;
      r_timer    <= w_timer_next;
    end
  end

  // Saturating error counter; rejected address and timeout never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  // Bus next-state: pop on a clk_en when idle, release on the following one.
  always_comb begin
    w_b_next = r_b_state;
    w_pop    = 1'b0;
    case (r_b_state)
      B_IDLE: begin
        if (clk_en && !w_empty) begin
          w_pop    = 1'b1;
          w_b_next = B_ACTIVE;
        end
      end
      B_ACTIVE: begin
        if (clk_en) w_b_next = B_IDLE;
      end
      default: w_b_next = B_IDLE;
    endcase
  end

  // Bus state and outputs; n_cs is registered as the inverse of B_ACTIVE so
  // it is low exactly while a write is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_state  <= B_IDLE;
      r_sid_addr <= '0;
      r_sid_data <= '0;
      r_sid_n_cs <= 1'b1;
    end else begin
      r_b_state  <= w_b_next;
      r_sid_n_cs <= (w_b_next != B_ACTIVE);
      if (w_pop) begin
        r_sid_addr <= w_dout.addr;
        r_sid_data <= w_dout.data;
      end
    end
  end

endmodule

// File: tb/tb_sid_cmd_parser.sv
// Directed bench for sid_cmd_parser: a vector table of address/data pairs
// plus hand-written sequences for timeout, FIFO fill, continuous clk_en,
// reset mid-write and error saturation.
module tb_sid_cmd_parser;
  import sid_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int LIMIT = 4000;

  logic                   clk;
  logic                   rst;
  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   clk_en;
  logic [4:0]             sid_addr;
  logic [7:0]             sid_data;
  logic                   sid_n_cs;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]             err_count;
  logic                   busy;

  sid_cmd_parser #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .clk_en        (clk_en),
    .sid_addr      (sid_addr),
    .sid_data      (sid_data),
    .sid_n_cs      (sid_n_cs),
    .fifo_level    (fifo_level),
    .err_count     (err_count),
    .busy          (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  int en_mode = 0;   // 0 stalled low, 1 periodic, 2 held high
  int en_period = 50;
  int en_cnt = 0;

  logic [12:0] wr_q [$];
  int          wid_q [$];
  int          fall_q [$];
  int          stable_err = 0;
  logic        prev_ncs = 1'b1;
  int          low_cnt = 0;
  logic [12:0] cur_wr = '0;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         has_b1;
    int         err_d;
    bit         exp_wr;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;
  vec_t vecs [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // clk_en source, updated away from the active edge
  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      case (en_mode)
        1: begin
          en_cnt++;
          if (en_cnt >= en_period) en_cnt = 0;
          clk_en = (en_cnt == 0);
        end
        2:       clk_en = 1'b1;
        default: clk_en = 1'b0;
      endcase
    end
  end

  // bus monitor: records each write, its low width and fall cycle
  initial begin
    forever begin
      @(negedge clk);
      if (prev_ncs && !sid_n_cs) begin
        cur_wr = {sid_addr, sid_data};
        wr_q.push_back(cur_wr);
        fall_q.push_back(cyc);
        low_cnt = 0;
      end
      if (!sid_n_cs) begin
        low_cnt++;
        if (!prev_ncs && ({sid_addr, sid_data} != cur_wr)) stable_err++;
      end else if (!prev_ncs) begin
        wid_q.push_back(low_cnt);
      end
      prev_ncs = sid_n_cs;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got wait bound expired, required DUT event", name);
  endtask

  // call at a negedge; returns at the negedge after the handshake edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) bound_fail("send_wait");
    @(negedge clk);
    hs_cyc = cyc;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) bound_fail("idle_wait");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int exp_err;
    int base;
    int wbase;
    int fbase;
    int n;
    int bad;
    logic [12:0] w;

    vecs[0] = '{8'h04, 8'h41, 1, 0, 1, 5'h04, 8'h41};
    vecs[1] = '{8'h25, 8'h00, 0, 1, 0, 5'h00, 8'h00};
    vecs[2] = '{8'h18, 8'h0F, 1, 0, 1, 5'h18, 8'h0F};
    vecs[3] = '{8'h1F, 8'h00, 1, 0, 1, 5'h1F, 8'h00};
    vecs[4] = '{8'h20, 8'h00, 0, 1, 0, 5'h00, 8'h00};
    vecs[5] = '{8'h00, 8'hFF, 1, 0, 1, 5'h00, 8'hFF};

    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_n_cs",   32'(sid_n_cs), 32'd1);
    check("rst_addr",   32'(sid_addr), 32'd0);
    check("rst_data",   32'(sid_data), 32'd0);
    check("rst_level",  32'(fifo_level), 32'd0);
    check("rst_err",    32'(err_count), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // vector table, clk_en every 50 clk
    en_period = 50;
    en_mode = 1;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      base = wr_q.size();
      send_byte(vecs[i].b0);
      if (vecs[i].has_b1) send_byte(vecs[i].b1);
      wait_idle();
      exp_err += vecs[i].err_d;
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(exp_err));
      check($sformatf("vec%0d_nwr", i), 32'(wr_q.size() - base), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr && wr_q.size() > base) begin
        check($sformatf("vec%0d_wr", i), 32'(wr_q[base]), 32'({vecs[i].ea, vecs[i].ed}));
        check($sformatf("vec%0d_width", i), 32'(wid_q[$]), 32'd50);
        if (i == 0) begin
          n = fall_q[$] - hs_cyc;
          check("vec0_latency_ok", 32'((n > 0) && (n <= 2 * 50 + 2)), 32'd1);
        end
      end
    end

    // orphaned address byte times out
    base = wr_q.size();
    send_byte(8'h02);
    repeat (TMO + 20) @(negedge clk);
    exp_err++;
    check("tmo_err", 32'(err_count), 32'(exp_err));
    send_byte(8'h01);
    send_byte(8'h77);
    wait_idle();
    check("tmo_nwr", 32'(wr_q.size() - base), 32'd1);
    if (wr_q.size() > base) check("tmo_next_wr", 32'(wr_q[base]), 32'h0177);

    // data byte on the last permitted cycle still wins
    base = wr_q.size();
    send_byte(8'h03);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h55);
    wait_idle();
    check("tmo_edge_in_err", 32'(err_count), 32'(exp_err));
    check("tmo_edge_in_nwr", 32'(wr_q.size() - base), 32'd1);
    if (wr_q.size() > base) check("tmo_edge_in_wr", 32'(wr_q[base]), 32'h0355);

    // one cycle later: timeout fires, then 0x77 is a bad address
    base = wr_q.size();
    send_byte(8'h06);
    repeat (TMO) @(negedge clk);
    send_byte(8'h77);
    wait_idle();
    exp_err += 2;
    check("tmo_edge_late_err", 32'(err_count), 32'(exp_err));
    check("tmo_edge_late_nwr", 32'(wr_q.size() - base), 32'd0);

    // fill FIFO with clk_en stalled, then drain
    en_mode = 0;
    repeat (2) @(negedge clk);
    base = wr_q.size();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_byte(8'(i));
          send_byte(8'(8'hA0 + i));
        end
      end
      begin
        n = 0;
        while (fifo_level != 4'd8 && n < LIMIT) begin
          @(negedge clk);
          n++;
        end
        if (n >= LIMIT) bound_fail("fill_wait");
        repeat (20) @(negedge clk);
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_tready", 32'(s_axis_tready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        en_period = 4;
        en_mode = 1;
      end
    join
    wait_idle();
    check("fill_nwr", 32'(wr_q.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (wr_q.size() > base + i) begin
        w = {5'(i), 8'(8'hA0 + i)};
        check($sformatf("fill_wr%0d", i), 32'(wr_q[base + i]), 32'(w));
      end
    end
    check("fill_err", 32'(err_count), 32'(exp_err));

    // clk_en held high: one clk write, one clk idle
    en_mode = 0;
    repeat (2) @(negedge clk);
    base = wr_q.size();
    wbase = wid_q.size();
    fbase = fall_q.size();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h11 + i));
      send_byte(8'(8'hC1 + i));
    end
    en_mode = 2;
    wait_idle();
    check("cont_nwr", 32'(wr_q.size() - base), 32'd3);
    if (wr_q.size() >= base + 3 && wid_q.size() >= wbase + 3 && fall_q.size() >= fbase + 3) begin
      for (int i = 0; i < 3; i++) begin
        w = {5'(8'h11 + i), 8'(8'hC1 + i)};
        check($sformatf("cont_wr%0d", i), 32'(wr_q[base + i]), 32'(w));
        check($sformatf("cont_width%0d", i), 32'(wid_q[wbase + i]), 32'd1);
      end
      check("cont_gap0", 32'(fall_q[fbase + 1] - fall_q[fbase]), 32'd2);
      check("cont_gap1", 32'(fall_q[fbase + 2] - fall_q[fbase + 1]), 32'd2);
    end

    // reset while a write is active with three more queued and a half pair
    en_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'h08 + i));
      send_byte(8'(8'h90 + i));
    end
    send_byte(8'h05);
    en_period = 50;
    en_mode = 1;
    n = 0;
    while (sid_n_cs && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) bound_fail("rst_active_wait");
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    check("pre_rst_addr", 32'(sid_addr), 32'h08);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_n_cs",  32'(sid_n_cs), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_addr",  32'(sid_addr), 32'd0);
    check("mid_rst_data",  32'(sid_data), 32'd0);
    rst = 1'b0;
    base = wr_q.size();
    repeat (300) @(negedge clk);
    check("post_rst_nwr", 32'(wr_q.size() - base), 32'd0);
    send_byte(8'h10);
    send_byte(8'h33);
    wait_idle();
    check("post_rst_nwr2", 32'(wr_q.size() - base), 32'd1);
    if (wr_q.size() > base) check("post_rst_wr", 32'(wr_q[base]), 32'h1033);
    check("post_rst_err", 32'(err_count), 32'd0);

    // error counter saturation
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      if (!s_axis_tready) bad++;
      send_byte(8'hFF);
      if (i == 253) check("sat_err_254", 32'(err_count), 32'hFE);
      if (i == 254) check("sat_err_255", 32'(err_count), 32'hFF);
    end
    check("sat_err_260", 32'(err_count), 32'hFF);
    check("sat_tready_drops", 32'(bad), 32'd0);

    check("addr_data_stable", 32'(stable_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
